// File: rtl/decoder24_low_seq_if.sv
// decoder24_low_seq_if
// Groups the command handshake and the decoded outputs of decoder24_low_seq.
//   scan_en    : request scan mode
//   in_valid   : command code valid
//   in_ready   : decoder can accept a command
//   y          : 2-bit command code
//   w          : active-low one-cold decoded output (4'b1111 = none)
//   code       : code currently driven on w (0 when inactive)
//   busy       : decoder is in a pulse or a scan
//   frame_done : one-clock pulse when the scan wraps 3 -> 0
// master = the side issuing commands; slave = the decoder.
interface decoder24_low_seq_if;
  logic       scan_en;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] y;
  logic [3:0] w;
  logic [1:0] code;
  logic       busy;
  logic       frame_done;

  modport master (
    output scan_en, in_valid, y,
    input  in_ready, w, code, busy, frame_done
  );

  modport slave (
    input  scan_en, in_valid, y,
    output in_ready, w, code, busy, frame_done
  );
endinterface

// File: rtl/decoder24_low_seq.sv
// decoder24_low_seq
// Sequenced 2-to-4 decoder with active-low one-cold outputs. In command mode
// a code taken through a valid/ready handshake is driven for PULSE_LEN clocks;
// in scan mode codes 0..3 are stepped through, DWELL clocks each.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : decoder24_low_seq_if.slave (scan_en, in_valid, y in;
//         in_ready, w, code, busy, frame_done out)
module decoder24_low_seq #(
  parameter int PULSE_LEN = 3,
  parameter int DWELL     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  decoder24_low_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    SCAN  = 2'd2
  } state_t;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] W_NONE     = 4'b1111;

  state_t     state_q, state_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [3:0] w_q,     w_d;
  logic [1:0] code_q,  code_d;
  logic       busy_q,  busy_d;
  logic       fd_q,    fd_d;

  // Active-low one-cold pattern for a code.
  function automatic logic [3:0] decode(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      w_q     <= W_NONE;
      code_q  <= 2'd0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    code_d  = code_q;
    busy_d  = busy_q;
    fd_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // scan_en wins over in_valid; in_ready is low then, so no handshake.
        if (bus.scan_en) begin
          state_d = SCAN;
          cnt_d   = 8'd0;
          code_d  = 2'd0;
          w_d     = decode(2'd0);
          busy_d  = 1'b1;
        end else if (bus.in_valid) begin
          state_d = PULSE;
          cnt_d   = 8'd0;
          code_d  = bus.y;
          w_d     = decode(bus.y);
          busy_d  = 1'b1;
        end else begin
          cnt_d   = 8'd0;
          code_d  = 2'd0;
          w_d     = W_NONE;
          busy_d  = 1'b0;
        end
      end
      PULSE: begin
        // Returning to IDLE guarantees one all-high clock between pulses.
        if (cnt_q == PULSE_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          code_d  = 2'd0;
          w_d     = W_NONE;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      SCAN: begin
        if (!bus.scan_en) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          code_d  = 2'd0;
          w_d     = W_NONE;
          busy_d  = 1'b0;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d   = 8'd0;
          code_d  = code_q + 2'd1;
          w_d     = decode(code_q + 2'd1);
          fd_d    = (code_q == 2'd3);
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        code_d  = 2'd0;
        w_d     = W_NONE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.in_ready   = (state_q == IDLE) && !bus.scan_en;
  assign bus.w          = w_q;
  assign bus.code       = code_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_decoder24_low_seq.sv
// tb_decoder24_low_seq
// Drives directed and random command/scan traffic into decoder24_low_seq and
// compares every output each clock against a behavioural reference model.
module tb_decoder24_low_seq;
  localparam int PULSE_LEN = 3;
  localparam int DWELL     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  decoder24_low_seq_if bus ();

  decoder24_low_seq #(.PULSE_LEN(PULSE_LEN), .DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: mode 0 = idle, 1 = command pulse, 2 = scan.
  // A pulse is described by the clocks left to show; a scan by the number of
  // clocks elapsed since it started.
  int m_mode  = 0;
  int m_left  = 0;
  int m_code  = 0;
  int m_ticks = 0;
  int fd_seen = 0;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_code = 0; m_ticks = 0;
  endtask

  task automatic model_edge();
    case (m_mode)
      0: begin
        if (bus.scan_en) begin
          m_mode = 2; m_ticks = 0;
        end else if (bus.in_valid) begin
          m_mode = 1; m_code = int'(bus.y); m_left = PULSE_LEN;
        end
      end
      1: begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 0;
      end
      default: begin
        if (!bus.scan_en) m_mode = 0;
        else m_ticks = m_ticks + 1;
      end
    endcase
  endtask

  task automatic check_one(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] e_w;
    logic [1:0] e_code;
    logic       e_busy, e_fd, e_rdy;
    int         c;
    e_w = 4'b1111; e_code = 2'd0; e_busy = 1'b0; e_fd = 1'b0;
    if (m_mode == 1) begin
      c = m_code;
      e_w = 4'b1111 & ~(4'(1) << c); e_code = 2'(c); e_busy = 1'b1;
    end else if (m_mode == 2) begin
      c = (m_ticks / DWELL) % 4;
      e_w = 4'b1111 & ~(4'(1) << c); e_code = 2'(c); e_busy = 1'b1;
      e_fd = (m_ticks != 0) && (m_ticks % (4 * DWELL) == 0);
    end
    e_rdy = (m_mode == 0) && !bus.scan_en;
    check_one({tag, ".w"},          bus.w,                 e_w);
    check_one({tag, ".code"},       {2'b00, bus.code},     {2'b00, e_code});
    check_one({tag, ".busy"},       {3'b000, bus.busy},    {3'b000, e_busy});
    check_one({tag, ".frame_done"}, {3'b000, bus.frame_done}, {3'b000, e_fd});
    check_one({tag, ".in_ready"},   {3'b000, bus.in_ready},   {3'b000, e_rdy});
    if (bus.frame_done === 1'b1) fd_seen++;
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    bus.scan_en = 1'b0; bus.in_valid = 1'b0; bus.y = 2'd0;
    model_reset();

    // Reset then idle
    @(negedge clk);
    check_all("reset");
    check_one("reset.w_const", bus.w, 4'b1111);
    rst = 1'b0;
    tick("idle");
    tick("idle");
    check_one("idle.ready_const", {3'b000, bus.in_ready}, 4'b0001);

    // Single command y=2
    bus.y = 2'd2; bus.in_valid = 1'b1;
    tick("cmd2");
    check_one("cmd2.w_const", bus.w, 4'b1011);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick("cmd2");
    check_one("cmd2.end_const", bus.w, 4'b1111);

    // Back-to-back with in_valid held
    bus.y = 2'd0; bus.in_valid = 1'b1;
    tick("b2b");
    check_one("b2b.first_const", bus.w, 4'b1110);
    bus.y = 2'd3;
    tick("b2b"); tick("b2b");
    tick("b2b");
    check_one("b2b.gap_const", bus.w, 4'b1111);
    tick("b2b");
    check_one("b2b.second_const", bus.w, 4'b0111);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick("b2b");

    // Scan for 20 clocks
    fd_seen = 0;
    bus.scan_en = 1'b1;
    for (int i = 0; i < 20; i++) tick("scan");
    check_one("scan.fd_count", 4'(fd_seen), 4'd1);
    bus.scan_en = 1'b0;
    tick("scan_exit");

    // Priority then abort at code 1
    bus.scan_en = 1'b1; bus.in_valid = 1'b1; bus.y = 2'd3;
    tick("prio");
    check_one("prio.w_const", bus.w, 4'b1110);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick("prio");
    check_one("prio.code1_const", {2'b00, bus.code}, 4'd1);
    bus.scan_en = 1'b0;
    tick("abort");
    check_one("abort.w_const", bus.w, 4'b1111);

    // Async reset mid-pulse
    bus.y = 2'd2; bus.in_valid = 1'b1;
    tick("pre_rst");
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    check_one("async_rst.w_const", bus.w, 4'b1111);
    tick("in_rst");
    rst = 1'b0;
    bus.y = 2'd1; bus.in_valid = 1'b1;
    tick("post_rst");
    check_one("post_rst.w_const", bus.w, 4'b1101);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick("post_rst");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) bus.scan_en = ~bus.scan_en;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.y        = 2'($urandom);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 79) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("rnd_async_rst");
      end
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/decoder24_low_seq.md
Name: decoder24_low_seq

Overview:
- Sequenced 2-to-4 decoder with active-low, one-cold outputs. It is the inverse of the team's 4-to-2 low-active encoder.
- Code mapping: 0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011, 3 -> 4'b0111. Idle/none = 4'b1111.
- Two modes:
  - Command mode: accepts a 2-bit code through a valid/ready handshake and drives the decoded pattern for a fixed pulse length.
  - Scan mode: steps through codes 0..3 automatically, with a fixed dwell per code.
- Drives strobe/select lines; its output can be looped back into the encoder for self-check.

Parameters:
- PULSE_LEN, 3, number of clocks the decoded pattern is held in command mode (legal range 1..255).
- DWELL, 4, number of clocks each code is held in scan mode (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- scan_en  input  1  1 = request scan mode.
- in_valid  input  1  command code valid.
- in_ready  output  1  block can accept a command. Combinational: (state==IDLE) && !scan_en.
- y  input  2  command code; sampled when in_valid && in_ready.
- w  output  4  registered active-low one-cold output; 4'b1111 when inactive.
- code  output  2  registered code currently driven on w; 0 when inactive.
- busy  output  1  registered; 1 in PULSE or SCAN.
- frame_done  output  1  registered one-clock pulse when scan wraps 3 -> 0.

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, w=4'b1111, code=0, busy=0, frame_done=0.
- Internal counter cnt is 8 bits wide. All code arithmetic is modulo 4.
- IDLE:
  - If scan_en=1: next state SCAN, code=0, w=4'b1110, busy=1, cnt=0. scan_en has priority over in_valid; no handshake occurs that cycle.
  - Else if in_valid=1: handshake completes, next state PULSE, code=y, w=decode(y), busy=1, cnt=0.
  - Else: outputs remain w=4'b1111, code=0, busy=0.
- PULSE:
  - in_ready=0. scan_en and in_valid are ignored.
  - cnt increments each clock.
  - When cnt==PULSE_LEN-1: next state IDLE, w=4'b1111, code=0, busy=0. w is therefore low for exactly PULSE_LEN clocks.
  - After a pulse, at least 1 IDLE clock (w=4'b1111) always separates consecutive pulses. With in_valid held high, the next pulse starts PULSE_LEN+1 clocks after the previous one started.
- SCAN:
  - in_ready=0.
  - If scan_en=0 is sampled: next state IDLE immediately (abort mid-dwell). w=4'b1111, code=0, busy=0, cnt=0, frame_done=0.
  - Else cnt increments. When cnt==DWELL-1: cnt=0 and code=code+1, with w updated to match.
  - On the 3 -> 0 wrap, frame_done=1 for that one clock.
  - Each code is therefore held exactly DWELL clocks.
- frame_done is 0 in all other cycles and in all non-SCAN states.
- Latency: a handshake at edge N gives w valid after edge N. This is the first of the PULSE_LEN active cycles.
- Invariant: w is always either 4'b1111 or exactly one bit 0. No other value is ever driven.
- Reset asserted mid-PULSE or mid-SCAN forces the reset values asynchronously. On release the block is in IDLE.
- PULSE_LEN=1 or DWELL=1 is legal: the pattern lasts one clock, and the scan advances every clock.

Test Plan:
1. Reset then idle: rst=1 then released, scan_en=0, in_valid=0 -> w=4'b1111, code=0, busy=0, in_ready=1.
2. Command: y=2, in_valid for 1 clock -> w=4'b1011, code=2, busy=1 for exactly 3 clocks, then w=4'b1111, in_ready=1.
3. Back-to-back: in_valid held high, y=0 then y=3 after the first handshake -> w=1110 for 3 clocks, then 1111 for 1 clock, then 0111 for 3 clocks.
4. Scan: scan_en=1 for 20 clocks -> w sequence 1110,1101,1011,0111,1110, each for 4 clocks. frame_done pulses once, on the clock where code goes 3 -> 0. in_ready=0 throughout.
5. Priority/abort: scan_en=1 and in_valid=1 together in IDLE -> SCAN, no handshake. Then drop scan_en while code=1 -> next clock w=4'b1111, busy=0.
6. Async reset mid-pulse: rst asserted during PULSE between clock edges -> w=4'b1111, busy=0 immediately. After release, a new command with y=1 gives w=4'b1101 for 3 clocks.
